// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame controller.
package uart_frame_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StLen,
      StPayload,
      StCsum,
      StDrain
   } state_e;

   localparam logic [1:0] ERR_DROP     = 2'd0;
   localparam logic [1:0] ERR_BAD_LEN  = 2'd1;
   localparam logic [1:0] ERR_BAD_CSUM = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   localparam logic [7:0] HDR0_DEFAULT = 8'hAA;
   localparam logic [7:0] HDR1_DEFAULT = 8'h55;

endpackage

// File: rtl/frame_fifo.sv
// Synchronous first-word-fall-through byte FIFO; flush wins over read and write.
module frame_fifo #(
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       wr_en,
   input  logic [7:0]                 wr_data,
   input  logic                       rd_en,
   output logic [7:0]                 rd_data,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;

   always_comb begin
      count_d = count_q;
      unique case ({wr_en, rd_en})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign empty   = (count_q == '0);
   assign count   = count_q;

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frames the UART byte stream (header, length, payload, checksum) and drains good payloads.
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_ctrl
   import uart_frame_pkg::*;
#(
   parameter int unsigned MAX_LEN     = 16,
   parameter logic [7:0]  HDR0        = HDR0_DEFAULT,
   parameter logic [7:0]  HDR1        = HDR1_DEFAULT,
   parameter int unsigned TIMEOUT_CYC = 50_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       m_last,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic       busy
);

   localparam int unsigned CW      = $clog2(MAX_LEN) + 1;
   localparam logic [8:0]  MaxLenW = 9'(MAX_LEN);

   state_e        state_q, state_d;
   logic [7:0]    len_q, len_d, cnt_q, cnt_d, csum_q, csum_d;
   logic          frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
   logic [1:0]    err_code_q, err_code_d;
   logic          fifo_wr, fifo_rd, fifo_flush, fifo_empty;
   logic [7:0]    fifo_rd_data;
   logic [CW-1:0] fifo_count;
   logic          timeout;

`ifdef UART_FRAME_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC);

   logic [TW-1:0] timer_q, timer_d;
   logic          timing;

   assign timing  = state_q inside {StHdr, StLen, StPayload, StCsum};
   assign timeout = timing && (timer_q == TW'(TIMEOUT_CYC - 1));

   always_comb begin
      timer_d = '0;
      if (timing && !rx_valid && !timeout) timer_d = timer_q + TW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) timer_q <= '0;
      else        timer_q <= timer_d;
   end
`else
   logic unused_timeout_cyc;
   assign unused_timeout_cyc = ^TIMEOUT_CYC;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         len_q       <= '0;
         cnt_q       <= '0;
         csum_q      <= '0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= ERR_DROP;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         csum_q      <= csum_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      csum_d      = csum_q;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;
      fifo_wr     = 1'b0;
      fifo_flush  = 1'b0;
      if (timeout) begin
         // The byte strobed on the expiry cycle is deliberately discarded.
         frame_err_d = 1'b1;
         err_code_d  = ERR_TIMEOUT;
         fifo_flush  = 1'b1;
         state_d     = StIdle;
      end else begin
         unique case (state_q)
            StIdle: if (rx_valid && rx_data == HDR0) state_d = StHdr;
            StHdr: begin
               if (rx_valid) begin
                  if (rx_data == HDR1)      state_d = StLen;
                  else if (rx_data != HDR0) state_d = StIdle;
               end
            end
            StLen: begin
               if (rx_valid) begin
                  if (rx_data != 8'd0 && {1'b0, rx_data} <= MaxLenW) begin
                     len_d   = rx_data;
                     csum_d  = rx_data;
                     cnt_d   = '0;
                     state_d = StPayload;
                  end else begin
                     frame_err_d = 1'b1;
                     err_code_d  = ERR_BAD_LEN;
                     state_d     = StIdle;
                  end
               end
            end
            StPayload: begin
               if (rx_valid) begin
                  fifo_wr = 1'b1;
                  csum_d  = csum_q + rx_data;
                  cnt_d   = cnt_q + 8'd1;
                  if (cnt_q + 8'd1 == len_q) state_d = StCsum;
               end
            end
            StCsum: begin
               if (rx_valid) begin
                  if (rx_data == csum_q) begin
                     frame_ok_d = 1'b1;
                     state_d    = StDrain;
                  end else begin
                     frame_err_d = 1'b1;
                     err_code_d  = ERR_BAD_CSUM;
                     fifo_flush  = 1'b1;
                     state_d     = StIdle;
                  end
               end
            end
            StDrain: begin
               if (rx_valid) begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_DROP;
               end
               if (fifo_rd && fifo_count == CW'(1)) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      busy    = (state_q != StIdle);
      m_valid = (state_q == StDrain) && !fifo_empty;
      m_last  = m_valid && (fifo_count == CW'(1));
      m_data  = m_valid ? fifo_rd_data : 8'h00;
      fifo_rd = m_valid && m_ready;
   end

   assign frame_ok  = frame_ok_q;
   assign frame_err = frame_err_q;
   assign err_code  = err_code_q;

   frame_fifo #(
      .DEPTH (MAX_LEN)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (fifo_flush),
      .wr_en   (fifo_wr),
      .wr_data (rx_data),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rd_data),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Scoreboard bench for uart_frame_ctrl: frame-level reference model feeds expectation queues.
module tb_uart_frame_ctrl;

   localparam int unsigned MaxLen = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       m_ready = 1'b0;
   logic [7:0] m_data;
   logic       m_valid, m_last, frame_ok, frame_err, busy;
   logic [1:0] err_code;

   uart_frame_ctrl #(
      .MAX_LEN     (MaxLen),
      .HDR0        (8'hAA),
      .HDR1        (8'h55),
      .TIMEOUT_CYC (100)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_last    (m_last),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .err_code  (err_code),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       is_err;
      logic [1:0] code;
   } evt_t;

   int         checks = 0;
   int         errors = 0;
   evt_t       exp_evt[$];
   logic [8:0] exp_data[$];
   logic [7:0] seg[$];
   bit         rand_ready = 1'b0;
   bit         rand_gap = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_evt(input logic is_err, input logic [1:0] code);
      evt_t e;
      e.is_err = is_err;
      e.code   = code;
      exp_evt.push_back(e);
   endtask

   // Monitor: samples at negedge, where every output and m_ready are settled.
   always @(negedge clk) begin
      evt_t       e;
      logic [8:0] d;
      if (rst_n) begin
         if (frame_ok || frame_err) begin
            checks++;
            if (exp_evt.size() == 0) begin
               errors++;
               $display("FAIL event: unexpected ok=%0b err=%0b code=%0d", frame_ok, frame_err,
                        err_code);
            end else begin
               e = exp_evt.pop_front();
               if (e.is_err !== frame_err || (frame_err && e.code !== err_code)) begin
                  errors++;
                  $display("FAIL event: got err=%0b code=%0d expected err=%0b code=%0d",
                           frame_err, err_code, e.is_err, e.code);
               end
            end
         end
         if (m_valid && m_ready) begin
            checks++;
            if (exp_data.size() == 0) begin
               errors++;
               $display("FAIL data: unexpected byte %02h last=%0b", m_data, m_last);
            end else begin
               d = exp_data.pop_front();
               if (d !== {m_last, m_data}) begin
                  errors++;
                  $display("FAIL data: got %02h last=%0b expected %02h last=%0b", m_data, m_last,
                           d[7:0], d[8]);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic strobe(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      if (rand_gap) repeat ($urandom_range(0, 3)) tick();
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 3000) begin
         tick();
         n++;
      end
      chk("wait_idle", busy, 0);
   endtask

   // Reference model: parse the byte sequence into frames from a known idle start.
   task automatic model();
      int         i = 0;
      int         n = seg.size();
      int         len;
      logic [7:0] sum;
      while (i < n) begin
         if (seg[i] != 8'hAA) begin
            i++;
            continue;
         end
         i++;
         while (i < n && seg[i] == 8'hAA) i++;
         if (i >= n) break;
         if (seg[i] != 8'h55) begin
            i++;
            continue;
         end
         i++;
         if (i >= n) break;
         len = int'(seg[i]);
         i++;
         if (len == 0 || len > int'(MaxLen)) begin
            push_evt(1'b1, 2'd1);
            continue;
         end
         if (i + len >= n) break;
         sum = 8'(len);
         for (int k = 0; k < len; k++) sum = sum + seg[i+k];
         if (seg[i+len] == sum) begin
            push_evt(1'b0, 2'd0);
            for (int k = 0; k < len; k++) exp_data.push_back({(k == len - 1), seg[i+k]});
         end else begin
            push_evt(1'b1, 2'd2);
         end
         i += len + 1;
      end
   endtask

   task automatic send_seg();
      model();
      foreach (seg[i]) strobe(seg[i]);
      wait_idle();
   endtask

   task automatic build_rand();
      logic [7:0] b, sum;
      int         kind, len;
      seg.delete();
      repeat ($urandom_range(0, 2)) begin
         b = 8'($urandom_range(0, 255));
         seg.push_back(b == 8'hAA ? 8'h12 : b);
      end
      kind = $urandom_range(0, 5);
      seg.push_back(8'hAA);
      if ($urandom_range(0, 1) == 1) seg.push_back(8'hAA);
      if (kind == 5) begin
         b = 8'($urandom_range(0, 255));
         seg.push_back((b == 8'hAA || b == 8'h55) ? 8'h00 : b);
         return;
      end
      seg.push_back(8'h55);
      if (kind == 4) begin
         seg.push_back(($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(MaxLen + 1, 255)));
         return;
      end
      len = $urandom_range(1, MaxLen);
      seg.push_back(8'(len));
      sum = 8'(len);
      for (int k = 0; k < len; k++) begin
         b = 8'($urandom_range(0, 255));
         seg.push_back(b);
         sum = sum + b;
      end
      seg.push_back(kind == 3 ? sum ^ 8'($urandom_range(1, 255)) : sum);
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_frame_ok", frame_ok, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_err_code", err_code, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      tick();

      // Good frame with cycle-exact drain
      m_ready = 1'b1;
      seg = '{8'hAA, 8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
      model();
      foreach (seg[i]) strobe(seg[i]);
      chk("good_frame_ok", frame_ok, 1);
      chk("good_m_valid", m_valid, 1);
      chk("good_data0", m_data, 8'h11);
      chk("good_last0", m_last, 0);
      tick();
      chk("good_data1", m_data, 8'h22);
      tick();
      chk("good_data2", m_data, 8'h33);
      chk("good_last2", m_last, 1);
      tick();
      chk("good_end_valid", m_valid, 0);
      chk("good_end_busy", busy, 0);

      // Backpressure holds the head stable
      m_ready = 1'b0;
      model();
      foreach (seg[i]) strobe(seg[i]);
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid", m_valid, 1);
         chk("bp_data", m_data, 8'h11);
         tick();
      end
      m_ready = 1'b1;
      wait_idle();

      // Bad checksum, then a good frame
      seg = '{8'hAA, 8'h55, 8'h02, 8'h01, 8'h02, 8'h00};
      model();
      foreach (seg[i]) strobe(seg[i]);
      chk("csum_err", frame_err, 1);
      chk("csum_code", err_code, 2);
      chk("csum_no_valid", m_valid, 0);
      wait_idle();
      seg = '{8'hAA, 8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
      send_seg();

      // Length and header errors
      seg = '{8'hAA, 8'h55, 8'h00};
      send_seg();
      seg = '{8'hAA, 8'h55, 8'h11};
      send_seg();
      repeat (3) tick();
      chk("code_hold", err_code, 1);
      seg = '{8'hAA, 8'hAA, 8'h55, 8'h02, 8'h05, 8'h06, 8'h0D};
      send_seg();
      seg = '{8'hAA, 8'h12};
      send_seg();

      // Drop during drain
      m_ready = 1'b0;
      seg = '{8'hAA, 8'h55, 8'h03, 8'h0A, 8'h0B, 8'h0C, 8'h24};
      model();
      foreach (seg[i]) strobe(seg[i]);
      push_evt(1'b1, 2'd0);
      strobe(8'hAA);
      chk("drop_err", frame_err, 1);
      chk("drop_code", err_code, 0);
      chk("drop_head", m_data, 8'h0A);
      m_ready = 1'b1;
      wait_idle();

      // Header byte on the final pop is dropped
      m_ready = 1'b0;
      seg = '{8'hAA, 8'h55, 8'h01, 8'h07, 8'h08};
      model();
      foreach (seg[i]) strobe(seg[i]);
      tick();
      tick();
      push_evt(1'b1, 2'd0);
      m_ready = 1'b1;
      strobe(8'hAA);
      chk("lastpop_err", frame_err, 1);
      chk("lastpop_busy", busy, 0);
      strobe(8'h55);
      chk("lastpop_hdr_dropped", busy, 0);

      // Reset mid-payload: no pulse, outputs back to reset values
      seg = '{8'hAA, 8'h55, 8'h00};
      send_seg();
      foreach (seg[i]) seg[i] = 8'h00;
      strobe(8'hAA);
      strobe(8'h55);
      strobe(8'h05);
      strobe(8'h01);
      strobe(8'h02);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_err_code", err_code, 0);
      chk("mid_rst_err", frame_err, 0);
      chk("mid_rst_valid", m_valid, 0);
      repeat (3) tick();
      seg = '{8'hAA, 8'h55, 8'h02, 8'h05, 8'h06, 8'h0D};
      send_seg();

      // Randomised frames with random gaps and backpressure
      rand_ready = 1'b1;
      rand_gap   = 1'b1;
      for (int s = 0; s < 40; s++) begin
         build_rand();
         send_seg();
      end
      rand_ready = 1'b0;
      rand_gap   = 1'b0;
      m_ready    = 1'b1;

      // Stalled frame
      strobe(8'hAA);
      strobe(8'h55);
      strobe(8'h04);
      strobe(8'h01);
`ifdef UART_FRAME_TIMEOUT_EN
      push_evt(1'b1, 2'd3);
      repeat (105) tick();
      chk("timeout_busy", busy, 0);
      chk("timeout_code", err_code, 3);
`else
      repeat (200) tick();
      chk("stall_busy", busy, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
`endif

      chk("evt_queue_empty", exp_evt.size(), 0);
      chk("data_queue_empty", exp_data.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
- Sequences the byte stream from the UART receiver into validated frames for the 2FSK modulator path.
- Hunts for the two-byte header, then captures length, payload and checksum.
- Buffers the payload and releases it downstream only after the checksum passes.
- Sits between the UART receive datapath (data + 1-cycle done pulse) and the modulator's valid/ready byte input.

Parameters:
- MAX_LEN, 16, maximum payload bytes per frame; also the buffer depth (power of 2, 4..256).
- HDR0, 8'hAA, first header byte.
- HDR1, 8'h55, second header byte.
- TIMEOUT_CYC, 50_000, inter-byte gap limit in clk cycles, about 11.5 byte times at 50 MHz / 115200.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- rx_data  in  8  received byte; valid only while rx_valid=1.
- rx_valid  in  1  one-cycle strobe, one byte per strobe.
- m_data  out  8  payload byte to the modulator.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts when m_valid & m_ready.
- m_last  out  1  marks the final payload byte of a frame.
- frame_ok  out  1  one-cycle pulse: checksum passed, drain begins.
- frame_err  out  1  one-cycle pulse: error occurred.
- err_code  out  2  qualifies frame_err: 0 DROP, 1 BAD_LEN, 2 BAD_CSUM, 3 TIMEOUT; holds its last value otherwise.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock is clk; reset is synchronous, active-low on rst_n, sampled only at posedge clk.
- Reset values: m_valid=0, m_last=0, m_data=0, frame_ok=0, frame_err=0, err_code=0, busy=0. State=IDLE, buffer empty, checksum=0, byte count=0, timer=0.
- Reset asserted mid-frame or mid-drain discards everything; no error pulse is generated.
- FSM states: IDLE, HDR, LEN, PAYLOAD, CSUM, DRAIN. Transitions below happen only on a cycle with rx_valid=1, except DRAIN exit and timeout.
- IDLE: byte==HDR0 -> HDR; any other byte is ignored.
- HDR: byte==HDR1 -> LEN. byte==HDR0 -> stay in HDR. Any other byte -> IDLE, no error.
- LEN: 1<=byte<=MAX_LEN -> latch length, checksum=byte, -> PAYLOAD. Otherwise (0 or >MAX_LEN) -> frame_err with code 1, -> IDLE.
- PAYLOAD: write byte to buffer, checksum=checksum+byte (8-bit, wraps mod 256), count+1. When count reaches length -> CSUM.
- CSUM: byte==checksum -> frame_ok, -> DRAIN. Mismatch -> frame_err with code 2, flush buffer, -> IDLE.
- frame_ok and frame_err are registered: they pulse the cycle after the rx_valid that caused them. m_valid rises in the same cycle as frame_ok.
- DRAIN: m_valid=1 while the buffer is non-empty. m_data is the buffer head (first-word-fall-through). m_last=1 exactly when the head is the final byte. Each m_valid&m_ready pops one byte.
- DRAIN exit: the cycle after the last byte is accepted, m_valid=0 and the state returns to IDLE. m_data/m_valid must stay stable while m_ready=0.
- rx_valid during DRAIN: byte dropped, frame_err with code 0. State and buffer are unaffected.
- A header byte arriving in the same cycle as the final pop is also dropped. IDLE is entered only after the pop.
- Buffer never overflows, since writes <= length <= MAX_LEN and the buffer is empty on entry to PAYLOAD.
- If frame_ok and frame_err would coincide (drop during DRAIN is impossible on the frame_ok cycle), frame_err takes priority for err_code.

Optional Feature:
- Macro: UART_FRAME_TIMEOUT_EN.
- Defined: in HDR, LEN, PAYLOAD and CSUM, a timer counts clk cycles since the last rx_valid and is cleared on each rx_valid. When it reaches TIMEOUT_CYC-1 -> frame_err with code 3, flush buffer, -> IDLE. An rx_valid in that same cycle is ignored. The timer is held at 0 in IDLE and DRAIN.
- Not defined: no timer logic; a stalled frame waits indefinitely; code 3 is never produced.

Decomposition:
- Shared package uart_frame_pkg holds:
  - the FSM state encoding,
  - err_code constants ERR_DROP=0, ERR_BAD_LEN=1, ERR_BAD_CSUM=2, ERR_TIMEOUT=3,
  - default HDR0/HDR1 values.
- One natural sub-module: frame_fifo.
  - Synchronous FWFT FIFO, depth MAX_LEN, 8 bits wide.
  - Ports: wr_en, wr_data, rd_en, rd_data, empty, count, flush.
  - flush takes priority over wr_en/rd_en.

Test Plan:
- Good frame: AA 55 03 11 22 33 69, m_ready=1 -> frame_ok pulse one cycle after the 69 strobe. m_data 11,22,33 on consecutive cycles, m_last only on 33, then IDLE with busy=0.
- Backpressure: same frame with m_ready low for 5 cycles after frame_ok -> m_valid=1 and m_data=11 held stable; bytes emerge in order once m_ready rises.
- Bad checksum: AA 55 02 01 02 00 -> frame_err with err_code=2. m_valid never asserts, and a following good frame is delivered correctly.
- Length and header errors:
  - AA 55 00 -> err_code=1.
  - AA 55 11 (with MAX_LEN=16) -> err_code=1.
  - AA AA 55 02 05 06 0D -> accepted (repeated HDR0).
  - AA 12 -> silent return to IDLE.
- Drop and reset: a byte strobed during DRAIN -> frame_err with err_code=0 and the drain completes intact. rst_n=0 for 1 cycle mid-PAYLOAD -> all outputs at reset values next cycle, no error pulse.
- Timeout (macro defined, TIMEOUT_CYC=100): AA 55 04 01, then idle 100 cycles -> frame_err with err_code=3. With the macro undefined, the same stimulus stays busy=1 indefinitely.
